// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one uart_tx byte stream between NUM_SRC byte sources.
// The grant takes effect 1 cycle after s_tvalid, with a combinational pass-through while granted; m_tready feeds straight back to the granted source's s_tready.
module uart_tx_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  output logic [NUM_SRC-1:0]         s_tready,
  input  logic [8*NUM_SRC-1:0]       s_tdata,
  input  logic [NUM_SRC-1:0]         s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [7:0]                 m_tdata,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_SRC);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {ARB = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_ptr;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] win_id;
  logic           win_vld;
  logic [BW-1:0]  burst_cnt;
  logic [TW-1:0]  idle_cnt;
  logic           src_vld;
  logic           src_last;
  logic           hs;
  logic           timeout;
  logic           release_grant;

  // Scan starts one past the previous owner so a busy source cannot starve the others.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = IDW'((int'(last_ptr) + k) % NUM_SRC);
      if (!win_vld && s_tvalid[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  assign src_vld  = s_tvalid[grant_id];
  assign src_last = s_tlast[grant_id];
  assign m_tdata  = s_tdata[{grant_id, 3'b000} +: 8];
  assign busy     = (state == GRANT);

  assign hs      = (state == GRANT) && src_vld && m_tready;
  // Timeout only fires while the source is idle, so a presented byte is never withdrawn.
  assign timeout = (state == GRANT) && !src_vld && (idle_cnt == TW'(IDLE_TIMEOUT - 1));
  assign release_grant = (hs && (src_last || (burst_cnt == BW'(MAX_BURST - 1)))) || timeout;

  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    s_tready  = '0;
    case (state)
      ARB: begin
        if (win_vld) state_nxt = GRANT;
      end
      GRANT: begin
        m_tvalid           = src_vld;
        s_tready[grant_id] = m_tready;
        if (release_grant) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id  <= '0;
      last_ptr  <= IDW'(NUM_SRC - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == ARB) begin
      if (win_vld) begin
        grant_id  <= win_id;
        burst_cnt <= '0;
        idle_cnt  <= '0;
      end
    end else begin
      if (hs) begin
        burst_cnt <= burst_cnt + 1'b1;
        idle_cnt  <= '0;
      end else if (!src_vld) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (release_grant) last_ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed sources, a per-cycle reference model and per-source byte scoreboards.
module tb_uart_tx_arbiter;
  localparam int N      = 4;
  localparam int MB     = 4;
  localparam int IT     = 8;
  localparam int BP_LOW = 434;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tready;
  logic [8*N-1:0] s_tdata = '0;
  logic [N-1:0]   s_tlast = '0;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic [7:0]     m_tdata;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(.NUM_SRC(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [8:0] src_q [N][$];
  logic [7:0] sb_q  [N][$];
  logic [N-1:0] hs_seen = '0;
  bit   bp_mode = 0;
  int   bp_cnt = 0;
  bit   rdy_force = 1;

  int hs_src[$];
  int hs_dat[$];
  int hs_cyc[$];
  int rise_gid[$];
  int rise_cyc[$];
  int fall_cyc[$];

  // Sources: present queue heads, retire a byte after its observed handshake.
  logic [8:0] head;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        head = src_q[i][0];
        s_tvalid[i]       = 1'b1;
        s_tdata[8*i +: 8] = head[7:0];
        s_tlast[i]        = head[8];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
    hs_seen = '0;
    if (bp_mode) begin
      bp_cnt++;
      m_tready = ((bp_cnt % (BP_LOW + 1)) == BP_LOW);
    end else begin
      m_tready = rdy_force;
    end
  end

  // Reference model: owner, bytes sent this grant, idle cycles this grant.
  bit mg = 0;
  int mown = 0, mlast = N - 1, mgid = 0, mbytes = 0, midle = 0, mc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mg = 0; mlast = N - 1; mgid = 0; mbytes = 0; midle = 0;
    end else if (mg) begin
      if (s_tvalid[mown] && m_tready) begin
        mbytes++;
        midle = 0;
        if (s_tlast[mown] || mbytes == MB) begin mg = 0; mlast = mown; end
      end else if (!s_tvalid[mown]) begin
        midle++;
        if (midle == IT) begin mg = 0; mlast = mown; end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        mc = (mlast + k) % N;
        if (!mg && s_tvalid[mc]) begin
          mg = 1; mown = mc; mgid = mc; mbytes = 0; midle = 0;
        end
      end
    end
  end

  logic       exp_mv;
  logic [N-1:0] exp_sr;
  logic [7:0] exp_b;
  int         hsrc;
  bit         prev_busy = 0;
  always @(negedge clk) begin
    exp_mv = mg && s_tvalid[mown];
    exp_sr = '0;
    if (mg && m_tready) exp_sr[mown] = 1'b1;
    checks++;
    if (m_tvalid !== exp_mv || s_tready !== exp_sr || busy !== mg || grant_id !== 2'(mgid) ||
        (exp_mv && m_tdata !== s_tdata[8*mown +: 8])) begin
      errors++;
      $display("FAIL model cyc %0d: got mv=%b sr=%b busy=%b gid=%0d dat=%h, want mv=%b sr=%b busy=%b gid=%0d dat=%h",
               cyc, m_tvalid, s_tready, busy, grant_id, m_tdata, exp_mv, exp_sr, mg, mgid, s_tdata[8*mown +: 8]);
    end
    if (m_tvalid === 1'b1 && m_tready) begin
      hsrc = int'(grant_id);
      checks++;
      if (sb_q[hsrc].size() == 0) begin
        errors++;
        $display("FAIL scoreboard cyc %0d: src %0d byte %h with nothing outstanding", cyc, hsrc, m_tdata);
      end else begin
        exp_b = sb_q[hsrc].pop_front();
        if (m_tdata !== exp_b) begin
          errors++;
          $display("FAIL scoreboard cyc %0d: src %0d got %h want %h", cyc, hsrc, m_tdata, exp_b);
        end
      end
      hs_src.push_back(hsrc);
      hs_dat.push_back(int'(m_tdata));
      hs_cyc.push_back(cyc);
    end
    hs_seen = s_tvalid & s_tready;
    if (busy && !prev_busy) begin rise_gid.push_back(int'(grant_id)); rise_cyc.push_back(cyc); end
    if (!busy && prev_busy) fall_cyc.push_back(cyc);
    prev_busy = busy;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input bit last);
    src_q[s].push_back({last, d});
    sb_q[s].push_back(d);
  endtask

  task automatic clear_logs();
    hs_src.delete(); hs_dat.delete(); hs_cyc.delete();
    rise_gid.delete(); rise_cyc.delete(); fall_cyc.delete();
  endtask

  task automatic wait_busy(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (busy) ok = 1;
    end
    if (!ok) begin errors++; checks++; $display("FAIL %s: no grant within %0d cycles", name, budget); end
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy && sb_q[0].size() == 0 && sb_q[1].size() == 0 &&
          sb_q[2].size() == 0 && sb_q[3].size() == 0) ok = 1;
    end
    if (!ok) begin errors++; checks++; $display("FAIL %s: not drained within %0d cycles", name, budget); end
  endtask

  int exp3_gid[5] = '{0, 1, 2, 3, 0};
  int exp3_dat[5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA1};
  int exp4_src[12] = '{1, 1, 1, 1, 3, 3, 1, 1, 1, 1, 1, 1};
  int exp4_dat[12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
  int exp4_gid[4] = '{1, 3, 1, 1};

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset grant_id", int'(grant_id), 0);
    check("reset m_tvalid", int'(m_tvalid), 0);
    check("reset s_tready", int'(s_tready), 0);
    rst = 1'b0;

    // Round-robin from reset: scan starts at source 0.
    @(negedge clk); #1;
    clear_logs();
    push(0, 8'hA0, 1); push(0, 8'hA1, 1);
    push(1, 8'hB1, 1); push(2, 8'hC2, 1); push(3, 8'hD3, 1);
    wait_drain(200, "rr drain");
    check("rr grant count", rise_gid.size(), 5);
    check("rr byte count", hs_dat.size(), 5);
    for (int i = 0; i < 5 && i < rise_gid.size() && i < hs_dat.size(); i++) begin
      check($sformatf("rr grant %0d", i), rise_gid[i], exp3_gid[i]);
      check($sformatf("rr byte %0d", i), hs_dat[i], exp3_dat[i]);
      if (i > 0) check($sformatf("rr gap %0d", i), rise_cyc[i] - rise_cyc[i-1], 2);
    end

    // Single source packet.
    clear_logs();
    push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
    wait_drain(200, "single drain");
    check("single grant count", rise_gid.size(), 1);
    check("single byte count", hs_dat.size(), 3);
    if (rise_gid.size() == 1 && hs_dat.size() == 3 && fall_cyc.size() == 1) begin
      check("single grant id", rise_gid[0], 2);
      check("single byte0", hs_dat[0], 8'h41);
      check("single byte1", hs_dat[1], 8'h42);
      check("single byte2", hs_dat[2], 8'h43);
      check("single busy drop", fall_cyc[0] - hs_cyc[2], 1);
    end

    // Burst limit forces rotation to a waiting source.
    clear_logs();
    for (int i = 0; i < 10; i++) push(1, 8'(8'h10 + i), 0);
    wait_busy(50, "burst grant");
    push(3, 8'h30, 0); push(3, 8'h31, 1);
    wait_drain(300, "burst drain");
    check("burst byte count", hs_src.size(), 12);
    for (int i = 0; i < 12 && i < hs_src.size(); i++) begin
      check($sformatf("burst src %0d", i), hs_src[i], exp4_src[i]);
      check($sformatf("burst byte %0d", i), hs_dat[i], exp4_dat[i]);
    end
    check("burst grant count", rise_gid.size(), 4);
    for (int i = 0; i < 4 && i < rise_gid.size(); i++)
      check($sformatf("burst grant %0d", i), rise_gid[i], exp4_gid[i]);

    // Idle timeout releases a silent owner.
    clear_logs();
    push(0, 8'h50, 0);
    wait_busy(50, "timeout grant");
    push(1, 8'h51, 1);
    wait_drain(200, "timeout drain");
    check("timeout grants", rise_gid.size(), 2);
    if (rise_gid.size() == 2 && hs_cyc.size() == 2 && fall_cyc.size() >= 1) begin
      check("timeout first owner", rise_gid[0], 0);
      check("timeout next owner", rise_gid[1], 1);
      check("timeout release delay", fall_cyc[0] - hs_cyc[0], 9);
      check("timeout regrant delay", rise_cyc[1] - hs_cyc[0], 10);
    end

    // Reset asserted with a byte offered to the link.
    rdy_force = 0;
    push(3, 8'hE3, 1);
    wait_busy(50, "reset grant");
    rdy_force = 1;
    @(posedge clk); #2;
    check("pre-reset s_tready", int'(s_tready), 8);
    rst = 1'b1;
    #1;
    check("mid-reset s_tready", int'(s_tready), 0);
    check("mid-reset m_tvalid", int'(m_tvalid), 0);
    check("mid-reset busy", int'(busy), 0);
    check("mid-reset grant_id", int'(grant_id), 0);
    push(0, 8'hE0, 1);
    repeat (2) @(negedge clk);
    #1;
    clear_logs();
    rst = 1'b0;
    wait_drain(200, "post-reset drain");
    check("post-reset grants", rise_gid.size(), 2);
    if (rise_gid.size() == 2 && hs_dat.size() == 2) begin
      check("post-reset first owner", rise_gid[0], 0);
      check("post-reset second owner", rise_gid[1], 3);
      check("post-reset byte0", hs_dat[0], 8'hE0);
      check("post-reset byte1", hs_dat[1], 8'hE3);
    end

    // uart_tx-rate backpressure, random bytes from three sources.
    clear_logs();
    for (int i = 0; i < 64; i++)
      push($urandom_range(0, 2), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    bp_cnt = 0;
    bp_mode = 1;
    wait_drain(70000, "backpressure drain");
    bp_mode = 0;
    check("backpressure byte count", hs_dat.size(), 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
